// File: rtl/rgb_pipe_reg.sv
// DEPTH-stage valid/ready pipeline of skid slices carrying an r/g/b pixel.
// Each stage's upstream ready is its registered skid-empty flag, so ready never chains combinationally.
module rgb_pipe_reg #(
    parameter int             CW          = 8,
    parameter int             DEPTH       = 2,
    parameter bit             RESET_DATA  = 1'b1,
    parameter logic [CW-1:0]  RESET_VALUE = '0,
    parameter int             LW          = $clog2(2*DEPTH+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_r,
    input  logic [CW-1:0] in_g,
    input  logic [CW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_r,
    output logic [CW-1:0] out_g,
    output logic [CW-1:0] out_b,
    output logic [LW-1:0] level
);
    localparam int DW = 3 * CW;

    logic [DEPTH-1:0] main_v;
    logic [DEPTH-1:0] skid_v;
    logic [DW-1:0]    main_d [DEPTH];
    logic [DW-1:0]    skid_d [DEPTH];
    logic [DEPTH-1:0] up_valid;
    logic [DEPTH-1:0] dn_ready;
    logic [DW-1:0]    up_data [DEPTH];
    logic [LW-1:0]    level_q;
    logic             in_xfer;
    logic             out_xfer;

    // Reset gates the handshake outputs so nothing moves while it is held.
    assign in_ready  = ~skid_v[0] & ~reset;
    assign out_valid = main_v[DEPTH-1] & ~reset;
    assign {out_r, out_g, out_b} = main_d[DEPTH-1];
    assign level     = reset ? '0 : level_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign up_valid[k] = in_valid;
            assign up_data[k]  = {in_r, in_g, in_b};
        end else begin : g_mid
            assign up_valid[k] = main_v[k-1];
            assign up_data[k]  = main_d[k-1];
        end

        if (k == DEPTH - 1) begin : g_last
            assign dn_ready[k] = out_ready;
        end else begin : g_inner
            assign dn_ready[k] = ~skid_v[k+1];
        end

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                main_v[k] <= 1'b0;
                skid_v[k] <= 1'b0;
            end else if (!main_v[k] || dn_ready[k]) begin
                if (skid_v[k]) begin
                    main_v[k] <= 1'b1;
                    skid_v[k] <= 1'b0;
                end else begin
                    main_v[k] <= up_valid[k];
                end
            end else if (up_valid[k] && !skid_v[k]) begin
                skid_v[k] <= 1'b1;
            end
        end

        // Data only loads from a valid source, so idle inputs never disturb held values.
        always_ff @(posedge clk) begin
            if (RESET_DATA && reset) begin
                main_d[k] <= {3{RESET_VALUE}};
                skid_d[k] <= {3{RESET_VALUE}};
            end else if (!reset && !flush) begin
                if (!main_v[k] || dn_ready[k]) begin
                    if (skid_v[k]) begin
                        main_d[k] <= skid_d[k];
                    end else if (up_valid[k]) begin
                        main_d[k] <= up_data[k];
                    end
                end else if (up_valid[k] && !skid_v[k]) begin
                    skid_d[k] <= up_data[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            level_q <= '0;
        end else begin
            level_q <= level_q + LW'(in_xfer) - LW'(out_xfer);
        end
    end
endmodule

// File: tb/tb_rgb_pipe_reg.sv
// Bench for rgb_pipe_reg: a DEPTH=2/CW=8 instance and a DEPTH=1/CW=1 instance against a queue model.
module tb_rgb_pipe_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DEPTH=2, CW=8 instance
    logic       rst_a, flush_a, iv_a, ir_a, ov_a, or_a;
    logic [7:0] in_r_a, in_g_a, in_b_a, out_r_a, out_g_a, out_b_a;
    logic [2:0] level_a;

    rgb_pipe_reg #(.CW(8), .DEPTH(2), .RESET_DATA(1'b1), .RESET_VALUE(8'h5A)) dut_a (
        .clk(clk), .reset(rst_a), .flush(flush_a),
        .in_valid(iv_a), .in_ready(ir_a), .in_r(in_r_a), .in_g(in_g_a), .in_b(in_b_a),
        .out_valid(ov_a), .out_ready(or_a), .out_r(out_r_a), .out_g(out_g_a), .out_b(out_b_a),
        .level(level_a)
    );

    // DEPTH=1, CW=1 instance
    logic       rst_b, flush_b, iv_b, ir_b, ov_b, or_b;
    logic       in_r_b, in_g_b, in_b_b, out_r_b, out_g_b, out_b_b;
    logic [1:0] level_b;

    rgb_pipe_reg #(.CW(1), .DEPTH(1)) dut_b (
        .clk(clk), .reset(rst_b), .flush(flush_b),
        .in_valid(iv_b), .in_ready(ir_b), .in_r(in_r_b), .in_g(in_g_b), .in_b(in_b_b),
        .out_valid(ov_b), .out_ready(or_b), .out_r(out_r_b), .out_g(out_g_b), .out_b(out_b_b),
        .level(level_b)
    );

    logic [23:0] q_a[$];
    logic [2:0]  q_b[$];
    int cyc = 0;
    int n_in, n_out, first_in, first_out, last_out, lvl_max;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle on instance A: check held state, apply inputs, predict transfers from the model.
    task automatic step_a(input logic iv, input logic [23:0] d, input logic ordy, input logic fl);
        logic ix, ox, r0;
        @(negedge clk);
        check("level_a", 32'(level_a), 32'(q_a.size()));
        if (q_a.size() == 0) check("empty_out_valid_a", 32'(ov_a), 0);
        if (q_a.size() >= 4) check("full_in_ready_a", 32'(ir_a), 0);
        if (int'(level_a) > lvl_max) lvl_max = int'(level_a);
        iv_a = iv; {in_r_a, in_g_a, in_b_a} = d; or_a = ordy; flush_a = fl;
        #1;
        r0 = ir_a;
        or_a = ~ordy;
        #1;
        check("ready_indep_a", 32'(ir_a), 32'(r0));
        or_a = ordy;
        #1;
        ix = iv & ir_a;
        ox = ov_a & ordy;
        if (ox) begin
            if (q_a.size() == 0) begin
                check("out_from_empty_a", 32'(ox), 0);
            end else begin
                check("data_a", 32'({out_r_a, out_g_a, out_b_a}), 32'(q_a.pop_front()));
                n_out++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
        end
        if (fl) begin
            q_a.delete();
        end else if (ix) begin
            q_a.push_back(d);
            n_in++;
            if (first_in < 0) first_in = cyc;
        end
        cyc++;
    endtask

    task automatic step_b(input logic iv, input logic [2:0] d, input logic ordy);
        logic ix, ox;
        @(negedge clk);
        check("level_b", 32'(level_b), 32'(q_b.size()));
        if (q_b.size() == 0) check("empty_out_valid_b", 32'(ov_b), 0);
        iv_b = iv; {in_r_b, in_g_b, in_b_b} = d; or_b = ordy;
        #1;
        ix = iv & ir_b;
        ox = ov_b & ordy;
        if (ox) begin
            if (q_b.size() == 0) begin
                check("out_from_empty_b", 32'(ox), 0);
            end else begin
                check("data_b", 32'({out_r_b, out_g_b, out_b_b}), 32'(q_b.pop_front()));
                n_out++;
                if (first_out < 0) first_out = cyc;
            end
        end
        if (ix) begin
            q_b.push_back(d);
            n_in++;
            if (first_in < 0) first_in = cyc;
        end
        cyc++;
    endtask

    task automatic clear_counts();
        n_in = 0; n_out = 0; first_in = -1; first_out = -1; last_out = -1; lvl_max = 0;
    endtask

    initial begin
        rst_a = 1'b1; flush_a = 1'b0; iv_a = 1'b0; or_a = 1'b0;
        in_r_a = '0; in_g_a = '0; in_b_a = '0;
        rst_b = 1'b1; flush_b = 1'b0; iv_b = 1'b0; or_b = 1'b0;
        in_r_b = 1'b0; in_g_b = 1'b0; in_b_b = 1'b0;
        clear_counts();

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_ready_a", 32'(ir_a), 0);
            check("rst_out_valid_a", 32'(ov_a), 0);
            check("rst_level_a", 32'(level_a), 0);
        end
        rst_a = 1'b0;
        @(negedge clk);
        check("rst_data_a", 32'({out_r_a, out_g_a, out_b_a}), 32'h5A5A5A);
        check("post_rst_in_ready_a", 32'(ir_a), 1);

        // Latency and throughput with out_ready high
        clear_counts();
        for (int i = 0; i < 16; i++) step_a(1'b1, {8'(i), 8'(i + 1), 8'(i + 2)}, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step_a(1'b0, 24'h0, 1'b1, 1'b0);
        check("lat_count", 32'(n_out), 16);
        check("lat_latency", 32'(first_out - first_in), 2);
        check("lat_back_to_back", 32'(last_out - first_out), 15);
        check("lat_level_le2", 32'(lvl_max <= 2), 1);

        // Backpressure to full, then drain
        clear_counts();
        for (int i = 0; i < 6; i++) step_a(1'b1, 24'($urandom), 1'b0, 1'b0);
        check("bp_accepts", 32'(n_in), 4);
        @(negedge clk);
        check("bp_level", 32'(level_a), 4);
        check("bp_in_ready", 32'(ir_a), 0);
        for (int i = 0; i < 8; i++) step_a(1'b0, 24'h0, 1'b1, 1'b0);
        check("bp_drained", 32'(n_out), 4);

        // Random stall
        clear_counts();
        for (int s = 0; s < 20000 && n_out < 1000; s++)
            step_a((n_in < 1000) ? 1'($urandom_range(0, 1)) : 1'b0, 24'($urandom),
                   1'($urandom_range(0, 1)), 1'b0);
        check("rand_emitted", 32'(n_out), 1000);
        check("rand_model_empty", 32'(q_a.size()), 0);

        // Flush mid-stream
        clear_counts();
        for (int i = 0; i < 3; i++) step_a(1'b1, 24'($urandom_range(0, 24'hFEFFFF)), 1'b0, 1'b0);
        check("fl_loaded", 32'(n_in), 3);
        step_a(1'b1, 24'hFF0000, 1'b0, 1'b1);
        @(negedge clk);
        check("fl_level", 32'(level_a), 0);
        check("fl_out_valid", 32'(ov_a), 0);
        flush_a = 1'b0; iv_a = 1'b0;
        n_out = 0;
        for (int i = 0; i < 5; i++) step_a(1'b0, 24'h0, 1'b1, 1'b0);
        check("fl_nothing_emitted", 32'(n_out), 0);

        // DEPTH=1 / CW=1 instance: reset data, fill, reset while full
        @(negedge clk);
        check("rst_data_b", 32'({out_r_b, out_g_b, out_b_b}), 0);
        rst_b = 1'b0;
        clear_counts();
        for (int i = 0; i < 3; i++) step_b(1'b1, 3'($urandom), 1'b0);
        check("b_fill_accepts", 32'(n_in), 2);
        @(negedge clk);
        check("b_full_level", 32'(level_b), 2);
        check("b_full_in_ready", 32'(ir_b), 0);
        rst_b = 1'b1;
        iv_b = 1'b0;
        q_b.delete();
        @(negedge clk);
        check("b_rst_level", 32'(level_b), 0);
        check("b_rst_out_valid", 32'(ov_b), 0);
        rst_b = 1'b0;
        clear_counts();
        step_b(1'b1, 3'b101, 1'b1);
        step_b(1'b0, 3'b000, 1'b1);
        check("b_latency", 32'(first_out - first_in), 1);
        check("b_count", 32'(n_out), 1);
        for (int i = 0; i < 40; i++) step_b(1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) step_b(1'b0, 3'b000, 1'b1);
        check("b_rand_balance", 32'(n_out), 32'(n_in));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
